lcd_power_seq: RTL and testbench
================================

Name: lcd_power_seq

Overview:
- Sequences the LCD panel enable and power controls (lcd_en, lcd_pwr) that feed timing_control.
- Enforces a programmable delay between enable and power, on both power-up and power-down.
- Double-buffers the horizontal and vertical timing registers (LCD_TIMH, LCD_TIMV). Software writes reach the timing generator only while the panel is off, or at a frame boundary.
- Sits between the register bus decode and timing_control, in the cclk domain.

Parameters:
- PWR_DLY, 1000, cclk cycles between lcd_en rise and lcd_pwr rise, and between lcd_pwr fall and lcd_en fall; legal range 1..65535.
- CNT_W, 16, width of the delay counter; must hold PWR_DLY.

Ports:
- cclk  in  1  controller clock.
- rst  in  1  asynchronous reset, active-high.
- on_req  in  1  software panel-on request (level); 1 = on, 0 = off.
- frame_start  in  1  single-cycle pulse at start of frame, already synchronised to cclk.
- timh_wr  in  1  write strobe for the pending TIMH register.
- timh_wdata  in  32  TIMH write data (LCD_TIMH layout).
- timv_wr  in  1  write strobe for the pending TIMV register.
- timv_wdata  in  32  TIMV write data (LCD_TIMV layout).
- lcd_en  out  1  enable to timing_control.
- lcd_pwr  out  1  power to timing_control / LCDPWR pin.
- timh_active  out  32  TIMH value in use by timing_control.
- timv_active  out  32  TIMV value in use by timing_control.
- upd_pending  out  1  a written timing value is not yet active.
- seq_busy  out  1  sequencer is in PWR_UP_WAIT or PWR_DN_WAIT.
- seq_state  out  2  encoded state, for status readback.

Behaviour:
- Reset values: lcd_en=0, lcd_pwr=0, timh_active=0, timv_active=0, pending regs=0, upd_pending=0, seq_busy=0, state=OFF (2'd0), counter=0.
- All outputs are registered. Reset is asynchronous assert; release takes effect on the first cclk edge.

State machine (encoding OFF=0, PWR_UP_WAIT=1, ON=2, PWR_DN_WAIT=3):
- OFF: lcd_en=0, lcd_pwr=0. If on_req=1 → PWR_UP_WAIT, lcd_en=1 from the next cycle, counter loads PWR_DLY-1.
- PWR_UP_WAIT: lcd_en=1, lcd_pwr=0; counter decrements each cycle.
  - If on_req=0 → OFF immediately (lcd_en=0 next cycle; lcd_pwr never asserted).
  - Else if counter==0 → ON. lcd_pwr rises exactly PWR_DLY cycles after lcd_en rose.
- ON: lcd_en=1, lcd_pwr=1. If on_req=0 → PWR_DN_WAIT, lcd_pwr=0 next cycle, counter loads PWR_DLY-1.
- PWR_DN_WAIT: lcd_en=1, lcd_pwr=0; counter decrements. When counter==0 → OFF.
  - lcd_en falls exactly PWR_DLY cycles after lcd_pwr fell.
  - on_req is ignored in this state: power-down always completes. If on_req=1 on arrival in OFF, power-up restarts on the following cycle.
- seq_busy = (state==PWR_UP_WAIT) or (state==PWR_DN_WAIT).

Shadow timing registers:
- timh_wr / timv_wr load the pending TIMH / TIMV register on the next edge and set upd_pending.
- Transfer: pending→active for both registers, and upd_pending cleared, on the next edge when upd_pending=1 and either:
  - state==OFF, or
  - frame_start=1 (in any state other than OFF).
- A write in the same cycle as a transfer: active takes the old pending value; the new write lands in pending; upd_pending stays 1.
- Writes with no transfer overwrite pending (last write wins); active is never partially updated.
- frame_start with upd_pending=0 has no effect.
- Reset mid-sequence: both controls drop to 0 asynchronously, state → OFF, pending and active cleared.

Decomposition:
- Shared package lcd_pkg:
  - packed structs LCD_TIMH, LCD_TIMV, LCD_CTRL, LCD_LE;
  - enum PWR_STATE {OFF, PWR_UP_WAIT, ON, PWR_DN_WAIT} as 2-bit;
  - address constants LCD_TIMH_ADDR=32'hFFE1_0000, LCD_TIMV_ADDR=32'hFFE1_0004.
- One sub-module, lcd_timing_shadow: pending/active register pair plus upd_pending logic, instantiated once for TIMH+TIMV with a common transfer enable.

Test Plan:
1. PWR_DLY=8; reset, then on_req=1 at cycle 0 → lcd_en=1 at cycle 1, lcd_pwr=1 at cycle 9, seq_state 0→1→2, seq_busy=1 for cycles 1–8.
2. From ON, on_req=0 at cycle 0 → lcd_pwr=0 at cycle 1, lcd_en=0 at cycle 9; on_req pulsed 1 at cycle 4 is ignored; state ends OFF.
3. on_req=1 then 0 after 3 cycles (PWR_DLY=8) → lcd_en high 3 cycles, lcd_pwr never 1, state returns to OFF.
4. In OFF, timh_wr with 32'h0A0B_0C10 → timh_active=32'h0A0B_0C10 two cycles later; upd_pending=1 for exactly one cycle.
5. In ON, timv_wr 32'h0505_0A40 → upd_pending=1, timv_active unchanged until a frame_start pulse, then equals 32'h0505_0A40 one cycle later.
6. In ON, timv_wr 32'h1 coinciding with frame_start while pending=32'h2 → timv_active=32'h2, pending=32'h1, upd_pending stays 1; rst asserted mid-PWR_UP_WAIT → lcd_en=0 without a clock edge.

Source files
------------

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD controller slice: register layouts for the
// timing, control and line-end registers, their bus addresses, and the
// panel power sequencer state encoding.
// -----------------------------------------------------------------------------
package lcd_pkg;

  // Register bus addresses of the timing registers.
  localparam logic [31:0] LCD_TIMH_ADDR = 32'hFFE1_0000;
  localparam logic [31:0] LCD_TIMV_ADDR = 32'hFFE1_0004;

  // Horizontal timing: back porch, front porch, sync width, pixels per line.
  typedef struct packed {
    logic [7:0] hbp;
    logic [7:0] hfp;
    logic [7:0] hsw;
    logic [7:0] ppl;
  } LCD_TIMH;

  // Vertical timing: back porch, front porch, sync width, lines per panel.
  typedef struct packed {
    logic [7:0] vbp;
    logic [7:0] vfp;
    logic [5:0] vsw;
    logic [9:0] lpp;
  } LCD_TIMV;

  // Panel control register.
  typedef struct packed {
    logic [19:0] rsvd;
    logic        pwr;
    logic        bepo;
    logic        bebo;
    logic        bgr;
    logic        dual;
    logic        mono8;
    logic        tft;
    logic        bw;
    logic [2:0]  bpp;
    logic        en;
  } LCD_CTRL;

  // Line-end signal control register.
  typedef struct packed {
    logic [14:0] rsvd_hi;
    logic        le_en;
    logic [8:0]  rsvd_lo;
    logic [6:0]  led;
  } LCD_LE;

  // Power sequencer states; the encoding is visible on the status readback.
  typedef enum logic [1:0] {
    OFF         = 2'd0,
    PWR_UP_WAIT = 2'd1,
    ON          = 2'd2,
    PWR_DN_WAIT = 2'd3
  } PWR_STATE;

endpackage

// File: rtl/lcd_power_seq_if.sv
// -----------------------------------------------------------------------------
// lcd_power_seq_if
// Groups the sequencer's control/register-bus side and its outputs towards
// timing_control.
//   master : drives on_req, frame_start and the TIMH/TIMV write strobes/data,
//            observes the panel controls, active timing values and status.
//   slave  : the lcd_power_seq side of the same signals.
// -----------------------------------------------------------------------------
interface lcd_power_seq_if;
  import lcd_pkg::*;

  logic        on_req;
  logic        frame_start;
  logic        timh_wr;
  LCD_TIMH     timh_wdata;
  logic        timv_wr;
  LCD_TIMV     timv_wdata;

  logic        lcd_en;
  logic        lcd_pwr;
  LCD_TIMH     timh_active;
  LCD_TIMV     timv_active;
  logic        upd_pending;
  logic        seq_busy;
  logic [1:0]  seq_state;

  modport master (
    output on_req, frame_start, timh_wr, timh_wdata, timv_wr, timv_wdata,
    input  lcd_en, lcd_pwr, timh_active, timv_active, upd_pending, seq_busy,
           seq_state
  );

  modport slave (
    input  on_req, frame_start, timh_wr, timh_wdata, timv_wr, timv_wdata,
    output lcd_en, lcd_pwr, timh_active, timv_active, upd_pending, seq_busy,
           seq_state
  );

endinterface

// File: rtl/lcd_timing_shadow.sv
// -----------------------------------------------------------------------------
// lcd_timing_shadow
// Pending/active register pair for LCD_TIMH and LCD_TIMV. Software writes land
// in the pending copies; both active copies are refreshed together when an
// update is pending and the transfer enable is high, so the timing generator
// never sees a half-updated pair.
// Ports:
//   cclk, rst              clock, asynchronous active-high reset
//   timh_wr / timh_wdata   pending TIMH write
//   timv_wr / timv_wdata   pending TIMV write
//   xfer_en                transfer window (panel off, or frame boundary)
//   timh_active/timv_active values in use by timing_control
//   upd_pending            a written value is not yet active
// -----------------------------------------------------------------------------
module lcd_timing_shadow
  import lcd_pkg::*;
(
  input  logic    cclk,
  input  logic    rst,
  input  logic    timh_wr,
  input  LCD_TIMH timh_wdata,
  input  logic    timv_wr,
  input  LCD_TIMV timv_wdata,
  input  logic    xfer_en,
  output LCD_TIMH timh_active,
  output LCD_TIMV timv_active,
  output logic    upd_pending
);

  LCD_TIMH timh_pend;
  LCD_TIMV timv_pend;
  logic    xfer;

  assign xfer = upd_pending & xfer_en;

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      timh_pend   <= '0;
      timv_pend   <= '0;
      timh_active <= '0;
      timv_active <= '0;
      upd_pending <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments mean the transfer below copies the
      // pending value from before this edge, so a write coinciding with a
      // transfer stays pending instead of slipping straight into active.
      if (xfer) begin
        timh_active <= timh_pend;
        timv_active <= timv_pend;
      end
      if (timh_wr) timh_pend <= timh_wdata;
      if (timv_wr) timv_pend <= timv_wdata;

      if (timh_wr || timv_wr) upd_pending <= 1'b1;
      else if (xfer)          upd_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_power_seq.sv
// -----------------------------------------------------------------------------
// lcd_power_seq
// LCD panel power sequencer and timing-register double buffer (cclk domain).
// Raises lcd_en, waits PWR_DLY cycles, then raises lcd_pwr; on power-down drops
// lcd_pwr, waits PWR_DLY cycles, then drops lcd_en. A power-up can be aborted
// before lcd_pwr rises; a power-down always runs to completion.
// Parameters:
//   PWR_DLY  enable-to-power delay in cclk cycles, 1..65535
//   CNT_W    delay counter width, must hold PWR_DLY-1
// Ports:
//   cclk, rst  clock, asynchronous active-high reset
//   bus        slave side of lcd_power_seq_if (requests, register writes,
//              panel controls, active timing, status)
// -----------------------------------------------------------------------------
module lcd_power_seq
  import lcd_pkg::*;
#(
  parameter int unsigned PWR_DLY = 1000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic          cclk,
  input  logic          rst,
  lcd_power_seq_if.slave bus
);

  // The counter runs PWR_DLY-1 down to 0, so the wait state lasts exactly
  // PWR_DLY cycles including the cycle on which the counter reads zero.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PWR_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  PWR_STATE         state;
  logic [CNT_W-1:0] cnt;
  logic             lcd_en_q;
  logic             lcd_pwr_q;
  logic             seq_busy_q;
  logic             xfer_en;

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state      <= OFF;
      cnt        <= '0;
      lcd_en_q   <= 1'b0;
      lcd_pwr_q  <= 1'b0;
      seq_busy_q <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (bus.on_req) begin
            state      <= PWR_UP_WAIT;
            cnt        <= CNT_LOAD;
            lcd_en_q   <= 1'b1;
            seq_busy_q <= 1'b1;
          end
        end

        PWR_UP_WAIT: begin
          if (!bus.on_req) begin
            // Abort: power was never applied, so enable can drop at once.
            state      <= OFF;
            lcd_en_q   <= 1'b0;
            seq_busy_q <= 1'b0;
          end else if (cnt == '0) begin
            state      <= ON;
            lcd_pwr_q  <= 1'b1;
            seq_busy_q <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        ON: begin
          if (!bus.on_req) begin
            state      <= PWR_DN_WAIT;
            cnt        <= CNT_LOAD;
            lcd_pwr_q  <= 1'b0;
            seq_busy_q <= 1'b1;
          end
        end

        PWR_DN_WAIT: begin
          // on_req is deliberately ignored: the panel must see the full
          // power-off delay before enable is removed.
          if (cnt == '0) begin
            state      <= OFF;
            lcd_en_q   <= 1'b0;
            seq_busy_q <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: begin
          state      <= OFF;
          lcd_en_q   <= 1'b0;
          lcd_pwr_q  <= 1'b0;
          seq_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Timing updates are safe whenever the panel is off, otherwise only at the
  // start of a frame.
  assign xfer_en = (state == OFF) | bus.frame_start;

  lcd_timing_shadow u_shadow (
    .cclk        (cclk),
    .rst         (rst),
    .timh_wr     (bus.timh_wr),
    .timh_wdata  (bus.timh_wdata),
    .timv_wr     (bus.timv_wr),
    .timv_wdata  (bus.timv_wdata),
    .xfer_en     (xfer_en),
    .timh_active (bus.timh_active),
    .timv_active (bus.timv_active),
    .upd_pending (bus.upd_pending)
  );

  assign bus.lcd_en    = lcd_en_q;
  assign bus.lcd_pwr   = lcd_pwr_q;
  assign bus.seq_busy  = seq_busy_q;
  assign bus.seq_state = state;

endmodule

// File: tb/tb_lcd_power_seq.sv
// -----------------------------------------------------------------------------
// tb_lcd_power_seq
// Self-checking bench for lcd_power_seq with PWR_DLY=8: a table of per-cycle
// vectors, hand-written power sequences and double-buffer corner cases, an
// asynchronous reset check, and a randomized run against a reference model.
// -----------------------------------------------------------------------------
module tb_lcd_power_seq;

  localparam int DLY = 8;

  logic cclk = 1'b0;
  logic rst  = 1'b1;

  always #5 cclk = ~cclk;

  lcd_power_seq_if bus();

  lcd_power_seq #(.PWR_DLY(DLY), .CNT_W(16)) dut (
    .cclk (cclk),
    .rst  (rst),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model. The power side tracks which control lines are up and the
  // cycle number at which the current wait began; a line changes when the
  // elapsed cycle count reaches DLY. The shadow side holds the pending pair,
  // the active pair and a dirty flag.
  int          cyc;
  bit          m_en, m_pwr, m_dn;
  int          m_mark;
  logic [31:0] m_ph, m_pv, m_ah, m_av;
  bit          m_dirty;

  typedef struct {
    logic        on_req;
    logic        frame_start;
    logic        timh_wr;
    logic [31:0] timh_wdata;
    logic        timv_wr;
    logic [31:0] timv_wdata;
    logic        exp_en;
    logic        exp_pwr;
    logic [1:0]  exp_state;
    logic        exp_busy;
    logic        exp_upd;
    logic [31:0] exp_timh;
    logic [31:0] exp_timv;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge cclk);
    #1;
  endtask

  task automatic drive_idle();
    bus.on_req      = 1'b0;
    bus.frame_start = 1'b0;
    bus.timh_wr     = 1'b0;
    bus.timh_wdata  = '0;
    bus.timv_wr     = 1'b0;
    bus.timv_wdata  = '0;
  endtask

  task automatic model_reset();
    cyc = 0; m_en = 0; m_pwr = 0; m_dn = 0; m_mark = 0;
    m_ph = '0; m_pv = '0; m_ah = '0; m_av = '0; m_dirty = 0;
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    bit was_off;
    cyc++;
    was_off = !m_en;
    if (!m_en) begin
      if (bus.on_req) begin m_en = 1; m_mark = cyc; end
    end else if (m_pwr) begin
      if (!bus.on_req) begin m_pwr = 0; m_dn = 1; m_mark = cyc; end
    end else if (m_dn) begin
      if (cyc - m_mark == DLY) begin m_en = 0; m_dn = 0; end
    end else begin
      if (!bus.on_req) m_en = 0;
      else if (cyc - m_mark == DLY) m_pwr = 1;
    end
    if (m_dirty && (was_off || bus.frame_start)) begin
      m_ah = m_ph; m_av = m_pv; m_dirty = 0;
    end
    if (bus.timh_wr) begin m_ph = bus.timh_wdata; m_dirty = 1; end
    if (bus.timv_wr) begin m_pv = bus.timv_wdata; m_dirty = 1; end
  endtask

  task automatic check_model(input string tag);
    logic [1:0] st;
    st = !m_en ? 2'd0 : m_pwr ? 2'd2 : m_dn ? 2'd3 : 2'd1;
    check({tag, ".lcd_en"},      bus.lcd_en,      m_en);
    check({tag, ".lcd_pwr"},     bus.lcd_pwr,     m_pwr);
    check({tag, ".seq_state"},   bus.seq_state,   st);
    check({tag, ".seq_busy"},    bus.seq_busy,    m_en && !m_pwr);
    check({tag, ".upd_pending"}, bus.upd_pending, m_dirty);
    check({tag, ".timh_active"}, bus.timh_active, m_ah);
    check({tag, ".timv_active"}, bus.timv_active, m_av);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // inputs: on fs hwr hdata vwr vdata | en pwr st busy upd timh timv
    vecs[0] = '{0,0,1,32'h0A0B_0C10,0,32'h0,      0,0,2'd0,0,1,32'h0,         32'h0};
    vecs[1] = '{0,0,0,32'h0,        0,32'h0,      0,0,2'd0,0,0,32'h0A0B_0C10, 32'h0};
    vecs[2] = '{0,1,0,32'h0,        0,32'h0,      0,0,2'd0,0,0,32'h0A0B_0C10, 32'h0};
    vecs[3] = '{0,0,1,32'h22,       1,32'h11,     0,0,2'd0,0,1,32'h0A0B_0C10, 32'h0};
    vecs[4] = '{0,0,0,32'h0,        0,32'h0,      0,0,2'd0,0,0,32'h22,        32'h11};
    vecs[5] = '{1,0,0,32'h0,        0,32'h0,      1,0,2'd1,1,0,32'h22,        32'h11};
    vecs[6] = '{0,0,0,32'h0,        0,32'h0,      0,0,2'd0,0,0,32'h22,        32'h11};

    drive_idle();
    rst = 1'b1;
    #1;
    check("reset.lcd_en",      bus.lcd_en,      1'b0);
    check("reset.lcd_pwr",     bus.lcd_pwr,     1'b0);
    check("reset.seq_state",   bus.seq_state,   2'd0);
    check("reset.seq_busy",    bus.seq_busy,    1'b0);
    check("reset.upd_pending", bus.upd_pending, 1'b0);
    check("reset.timh_active", bus.timh_active, 32'h0);
    check("reset.timv_active", bus.timv_active, 32'h0);
    repeat (2) @(posedge cclk);
    @(negedge cclk);
    rst = 1'b0;
    step();

    // Table: shadow transfer while off, frame_start with nothing pending,
    // simultaneous writes, and a one-cycle power-up abort.
    for (int i = 0; i < 7; i++) begin
      bus.on_req      = vecs[i].on_req;
      bus.frame_start = vecs[i].frame_start;
      bus.timh_wr     = vecs[i].timh_wr;
      bus.timh_wdata  = vecs[i].timh_wdata;
      bus.timv_wr     = vecs[i].timv_wr;
      bus.timv_wdata  = vecs[i].timv_wdata;
      step();
      bus.frame_start = 1'b0;
      bus.timh_wr     = 1'b0;
      bus.timv_wr     = 1'b0;
      check($sformatf("vec%0d.lcd_en", i),      bus.lcd_en,      vecs[i].exp_en);
      check($sformatf("vec%0d.lcd_pwr", i),     bus.lcd_pwr,     vecs[i].exp_pwr);
      check($sformatf("vec%0d.seq_state", i),   bus.seq_state,   vecs[i].exp_state);
      check($sformatf("vec%0d.seq_busy", i),    bus.seq_busy,    vecs[i].exp_busy);
      check($sformatf("vec%0d.upd_pending", i), bus.upd_pending, vecs[i].exp_upd);
      check($sformatf("vec%0d.timh_active", i), bus.timh_active, vecs[i].exp_timh);
      check($sformatf("vec%0d.timv_active", i), bus.timv_active, vecs[i].exp_timv);
    end

    // Power-up: lcd_en at cycle 1, lcd_pwr at cycle DLY+1.
    bus.on_req = 1'b1;
    for (int c = 1; c <= DLY + 2; c++) begin
      step();
      check($sformatf("up%0d.lcd_en", c),    bus.lcd_en,    1'b1);
      check($sformatf("up%0d.lcd_pwr", c),   bus.lcd_pwr,   c > DLY);
      check($sformatf("up%0d.seq_state", c), bus.seq_state, (c > DLY) ? 2'd2 : 2'd1);
      check($sformatf("up%0d.seq_busy", c),  bus.seq_busy,  c <= DLY);
    end

    // Power-down with an ignored on_req pulse at cycle 4.
    bus.on_req = 1'b0;
    for (int c = 1; c <= DLY + 2; c++) begin
      step();
      check($sformatf("dn%0d.lcd_pwr", c),   bus.lcd_pwr,   1'b0);
      check($sformatf("dn%0d.lcd_en", c),    bus.lcd_en,    c <= DLY);
      check($sformatf("dn%0d.seq_state", c), bus.seq_state, (c <= DLY) ? 2'd3 : 2'd0);
      check($sformatf("dn%0d.seq_busy", c),  bus.seq_busy,  c <= DLY);
      bus.on_req = (c == 4);
    end

    // Aborted power-up: request held for three cycles.
    bus.on_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("abort%0d.lcd_en", c),    bus.lcd_en,    c <= 3);
      check($sformatf("abort%0d.lcd_pwr", c),   bus.lcd_pwr,   1'b0);
      check($sformatf("abort%0d.seq_state", c), bus.seq_state, (c <= 3) ? 2'd1 : 2'd0);
      if (c == 3) bus.on_req = 1'b0;
    end

    // While on, a TIMV write waits for frame_start.
    bus.on_req = 1'b1;
    repeat (DLY + 1) step();
    check("on.seq_state", bus.seq_state, 2'd2);
    bus.timv_wr = 1'b1; bus.timv_wdata = 32'h0505_0A40;
    step();
    bus.timv_wr = 1'b0;
    check("onwr.upd_pending", bus.upd_pending, 1'b1);
    check("onwr.timv_active", bus.timv_active, 32'h11);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("onhold%0d.timv_active", c), bus.timv_active, 32'h11);
      check($sformatf("onhold%0d.upd_pending", c), bus.upd_pending, 1'b1);
    end
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    check("onfs.timv_active", bus.timv_active, 32'h0505_0A40);
    check("onfs.timh_active", bus.timh_active, 32'h22);
    check("onfs.upd_pending", bus.upd_pending, 1'b0);

    // Write coinciding with a transfer.
    bus.timv_wr = 1'b1; bus.timv_wdata = 32'h2;
    step();
    bus.timv_wr = 1'b0;
    check("coll_pre.upd_pending", bus.upd_pending, 1'b1);
    bus.timv_wr = 1'b1; bus.timv_wdata = 32'h1; bus.frame_start = 1'b1;
    step();
    bus.timv_wr = 1'b0; bus.frame_start = 1'b0;
    check("coll.timv_active", bus.timv_active, 32'h2);
    check("coll.upd_pending", bus.upd_pending, 1'b1);
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    check("coll_post.timv_active", bus.timv_active, 32'h1);
    check("coll_post.upd_pending", bus.upd_pending, 1'b0);

    // Asynchronous reset in the middle of a power-up wait.
    bus.on_req = 1'b0;
    repeat (DLY + 1) step();
    check("off.seq_state", bus.seq_state, 2'd0);
    bus.on_req = 1'b1;
    repeat (3) step();
    check("midup.lcd_en", bus.lcd_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst.lcd_en",      bus.lcd_en,      1'b0);
    check("arst.lcd_pwr",     bus.lcd_pwr,     1'b0);
    check("arst.seq_state",   bus.seq_state,   2'd0);
    check("arst.seq_busy",    bus.seq_busy,    1'b0);
    check("arst.upd_pending", bus.upd_pending, 1'b0);
    check("arst.timh_active", bus.timh_active, 32'h0);
    check("arst.timv_active", bus.timv_active, 32'h0);
    drive_idle();
    @(negedge cclk);
    rst = 1'b0;
    step();

    // Randomized run against the reference model.
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) bus.on_req = ~bus.on_req;
      bus.frame_start = ($urandom_range(0, 7) == 0);
      bus.timh_wr     = ($urandom_range(0, 3) == 0);
      bus.timh_wdata  = $urandom;
      bus.timv_wr     = ($urandom_range(0, 3) == 0);
      bus.timv_wdata  = $urandom;
      model_edge();
      step();
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
